// File: rtl/cv32e40x_obi_limit_interface.sv
// OBI master adapter: forwards trans_* requests onto the OBI A channel, caps in-flight
// transfers at MAX_OUTSTANDING, optionally registers the R channel and flags unsolicited rvalid.
module cv32e40x_obi_limit_interface #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_REG        = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     trans_valid_i,
  output logic                                     trans_ready_o,
  input  logic [ADDR_WIDTH-1:0]                    trans_addr_i,
  input  logic                                     trans_we_i,
  input  logic [DATA_WIDTH/8-1:0]                  trans_be_i,
  input  logic [DATA_WIDTH-1:0]                    trans_wdata_i,
  output logic                                     resp_valid_o,
  output logic [DATA_WIDTH-1:0]                    resp_rdata_o,
  output logic                                     resp_err_o,
  output logic                                     obi_req_o,
  input  logic                                     obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]                    obi_addr_o,
  output logic                                     obi_we_o,
  output logic [DATA_WIDTH/8-1:0]                  obi_be_o,
  output logic [DATA_WIDTH-1:0]                    obi_wdata_o,
  input  logic                                     obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    obi_rdata_i,
  input  logic                                     obi_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     protocol_err_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {TRANSPARENT, REGISTERED} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  prot_err_q, prot_err_d;
  logic                  limit_ok, inc, dec;

  // A-channel steering, outstanding tracking and unsolicited-response detection
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    prot_err_d    = prot_err_q;
    limit_ok      = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    obi_req_o     = 1'b0;
    trans_ready_o = 1'b0;
    obi_addr_o    = trans_addr_i;
    obi_we_o      = trans_we_i;
    obi_be_o      = trans_be_i;
    obi_wdata_o   = trans_wdata_i;

    case (state_q)
      TRANSPARENT: begin
        obi_req_o     = trans_valid_i && limit_ok;
        trans_ready_o = limit_ok && obi_gnt_i;
        if (obi_req_o && !obi_gnt_i) begin
          addr_d  = trans_addr_i;
          we_d    = trans_we_i;
          be_d    = trans_be_i;
          wdata_d = trans_wdata_i;
          state_d = REGISTERED;
        end
      end
      REGISTERED: begin
        // Parked request: payload comes from the hold registers until granted
        obi_req_o     = 1'b1;
        trans_ready_o = obi_gnt_i;
        obi_addr_o    = addr_q;
        obi_we_o      = we_q;
        obi_be_o      = be_q;
        obi_wdata_o   = wdata_q;
        if (obi_gnt_i) state_d = TRANSPARENT;
      end
      default: state_d = TRANSPARENT;
    endcase

    // Requests are suppressed while reset is held, even with trans_valid_i high
    if (!rst_n) begin
      obi_req_o     = 1'b0;
      trans_ready_o = 1'b0;
    end

    inc = obi_req_o && obi_gnt_i;
    dec = obi_rvalid_i && (cnt_q != '0);
    if (inc && !dec && limit_ok)  cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc)         cnt_d = cnt_q - CNT_W'(1);

    if (obi_rvalid_i && (cnt_q == '0)) prot_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TRANSPARENT;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign outstanding_o  = cnt_q;
  assign protocol_err_o = prot_err_q;

  if (RESP_REG != 0) begin : g_resp_reg
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    // Payload registers only load on rvalid so rdata holds between responses
    always_comb begin
      resp_valid_d = obi_rvalid_i;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      if (obi_rvalid_i) begin
        resp_rdata_d = obi_rdata_i;
        resp_err_d   = obi_err_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        resp_valid_q <= 1'b0;
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b0;
      end else begin
        resp_valid_q <= resp_valid_d;
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= resp_err_d;
      end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
  end else begin : g_resp_comb
    assign resp_valid_o = obi_rvalid_i;
    assign resp_rdata_o = obi_rdata_i;
    assign resp_err_o   = obi_err_i;
  end

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (obi_req_o && !obi_gnt_i) |=> obi_req_o);
  a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (obi_req_o && !obi_gnt_i) |=> $stable({obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o}));
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_cv32e40x_obi_limit_interface.sv
// Bench: dut0 (MAX_OUTSTANDING=2, combinational R path) against a scoreboard and a 3-cycle
// latency slave model; dut1 (MAX_OUTSTANDING=4, registered R path) for response timing and reset.
module tb_cv32e40x_obi_limit_interface;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk, rst_n;

  // dut0 signals
  logic        valid, trans_ready_o, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata, exp_addr;
  logic [3:0]  be;
  logic        resp_valid_o, resp_err_o, obi_req_o, obi_we_o, prot_err_o;
  logic [31:0] resp_rdata_o, obi_addr_o, obi_wdata_o;
  logic [3:0]  obi_be_o;
  logic [1:0]  outstanding_o;

  // dut1 signals
  logic        b_valid, b_ready, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_rdata;
  logic        b_resp_valid, b_resp_err, b_req, b_we_o, b_prot_err;
  logic [31:0] b_resp_rdata, b_addr_o, b_wdata_o;
  logic [3:0]  b_be_o;
  logic [2:0]  b_out;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t        exp_q[$];
  logic [31:0] pend_a[$];
  int          pend_t[$];

  cv32e40x_obi_limit_interface #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .RESP_REG(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(valid), .trans_ready_o(trans_ready_o), .trans_addr_i(addr),
    .trans_we_i(we), .trans_be_i(be), .trans_wdata_i(wdata),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(gnt), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(rvalid),
    .obi_rdata_i(rdata), .obi_err_i(err), .outstanding_o(outstanding_o),
    .protocol_err_o(prot_err_o)
  );

  cv32e40x_obi_limit_interface #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .RESP_REG(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(b_valid), .trans_ready_o(b_ready), .trans_addr_i(b_addr),
    .trans_we_i(we), .trans_be_i(be), .trans_wdata_i(wdata),
    .resp_valid_o(b_resp_valid), .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
    .obi_req_o(b_req), .obi_gnt_i(b_gnt), .obi_addr_o(b_addr_o), .obi_we_o(b_we_o),
    .obi_be_o(b_be_o), .obi_wdata_o(b_wdata_o), .obi_rvalid_i(b_rvalid),
    .obi_rdata_i(b_rdata), .obi_err_i(b_err), .outstanding_o(b_out),
    .protocol_err_o(b_prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Close the current cycle: scoreboard push/pop, slave bookkeeping, then next-cycle rvalid
  task automatic adv();
    exp_t e;
    if (valid && trans_ready_o) exp_q.push_back('{mem_f(exp_addr), 1'b0});
    if (obi_req_o && gnt) begin
      pend_a.push_back(obi_addr_o);
      pend_t.push_back(cyc + 3);
    end
    if (resp_valid_o) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 32'(resp_valid_o), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata_o, e.rdata);
        chk("resp_err", 32'(resp_err_o), 32'(e.err));
      end
    end
    @(posedge clk); #1;
    cyc++;
    rvalid = 1'b0; rdata = '0; err = 1'b0;
    if (pend_t.size() > 0 && pend_t[0] == cyc) begin
      rvalid = 1'b1;
      rdata  = mem_f(pend_a.pop_front());
      void'(pend_t.pop_front());
    end
  endtask

  task automatic drive_req(input logic [31:0] a);
    valid = 1'b1; addr = a; exp_addr = a;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; addr = '0; exp_addr = '0; we = 1'b0; be = 4'hF; wdata = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
    b_valid = 1'b0; b_addr = '0; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_err = 1'b0;

    // Reset state
    mid();
    chk("rst_req", 32'(obi_req_o), 32'd0);
    chk("rst_cnt", 32'(outstanding_o), 32'd0);
    chk("rst_prot", 32'(prot_err_o), 32'd0);
    chk("rst_b_resp_valid", 32'(b_resp_valid), 32'd0);
    chk("rst_b_resp_rdata", b_resp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back reads, gnt=1, 3-cycle response latency
    gnt = 1'b1;
    drive_req(32'h1000);
    mid(); chk("b2b0_req", 32'(obi_req_o), 32'd1); chk("b2b0_ready", 32'(trans_ready_o), 32'd1);
    chk("b2b0_cnt", 32'(outstanding_o), 32'd0); chk("b2b0_addr", obi_addr_o, 32'h1000);
    adv();
    drive_req(32'h1004);
    mid(); chk("b2b1_req", 32'(obi_req_o), 32'd1); chk("b2b1_cnt", 32'(outstanding_o), 32'd1);
    adv();
    drive_req(32'h1008);
    mid(); chk("blocked_req", 32'(obi_req_o), 32'd0); chk("blocked_ready", 32'(trans_ready_o), 32'd0);
    chk("blocked_cnt", 32'(outstanding_o), 32'd2);
    adv();
    mid(); chk("rv1_resp_valid", 32'(resp_valid_o), 32'd1); chk("rv1_req_blocked", 32'(obi_req_o), 32'd0);
    chk("rv1_cnt", 32'(outstanding_o), 32'd2);
    adv();
    mid(); chk("after_rv_req", 32'(obi_req_o), 32'd1); chk("after_rv_ready", 32'(trans_ready_o), 32'd1);
    chk("after_rv_cnt", 32'(outstanding_o), 32'd1); chk("after_rv_addr", obi_addr_o, 32'h1008);
    adv();
    valid = 1'b0;
    mid(); chk("same_cycle_gnt_rvalid_cnt", 32'(outstanding_o), 32'd1);
    adv();
    repeat (4) begin mid(); adv(); end
    mid(); chk("drain1_cnt", 32'(outstanding_o), 32'd0);

    // Grant held off 4 cycles; payload change while parked must be ignored
    adv();
    gnt = 1'b0;
    drive_req(32'h100);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) addr = 32'h200;
      gnt = (i == 4);
      mid();
      chk("park_req", 32'(obi_req_o), 32'd1);
      chk("park_addr", obi_addr_o, 32'h100);
      chk("park_ready", 32'(trans_ready_o), 32'(i == 4));
      adv();
    end
    valid = 1'b0; addr = 32'h300;
    mid(); chk("back_transparent_addr", obi_addr_o, 32'h300); chk("back_transparent_req", 32'(obi_req_o), 32'd0);
    adv();
    repeat (4) begin mid(); adv(); end
    mid(); chk("drain2_cnt", 32'(outstanding_o), 32'd0);
    adv();

    // Unsolicited response with nothing outstanding
    rvalid = 1'b1; rdata = 32'h1234_5678; err = 1'b1;
    exp_q.push_back('{32'h1234_5678, 1'b1});
    mid(); chk("unsol_resp_valid", 32'(resp_valid_o), 32'd1); chk("unsol_cnt", 32'(outstanding_o), 32'd0);
    adv();
    mid(); chk("unsol_prot", 32'(prot_err_o), 32'd1); chk("unsol_cnt_after", 32'(outstanding_o), 32'd0);
    chk("unsol_resp_drop", 32'(resp_valid_o), 32'd0);
    adv();
    repeat (3) begin mid(); adv(); end
    mid(); chk("unsol_prot_sticky", 32'(prot_err_o), 32'd1);
    adv();

    // Registered response path
    b_rvalid = 1'b1; b_rdata = 32'hDEAD_BEEF; b_err = 1'b1;
    mid(); chk("rreg_same_cycle_valid", 32'(b_resp_valid), 32'd0);
    adv();
    b_rvalid = 1'b0; b_rdata = 32'h0BAD_0BAD; b_err = 1'b0;
    mid(); chk("rreg_valid", 32'(b_resp_valid), 32'd1); chk("rreg_rdata", b_resp_rdata, 32'hDEAD_BEEF);
    chk("rreg_err", 32'(b_resp_err), 32'd1);
    adv();
    mid(); chk("rreg_valid_drop", 32'(b_resp_valid), 32'd0); chk("rreg_rdata_hold", b_resp_rdata, 32'hDEAD_BEEF);
    adv();

    // Reset while parked with two outstanding
    b_valid = 1'b1; b_gnt = 1'b1; b_addr = 32'hA0;
    mid(); chk("b_req0", 32'(b_req), 32'd1); adv();
    b_addr = 32'hA4;
    mid(); adv();
    b_addr = 32'hA8; b_gnt = 1'b0;
    mid(); chk("b_park_cnt", 32'(b_out), 32'd2); adv();
    mid(); chk("b_park_req", 32'(b_req), 32'd1); chk("b_park_addr", b_addr_o, 32'hA8);
    chk("b_park_cnt2", 32'(b_out), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(b_req), 32'd0); chk("midrst_cnt", 32'(b_out), 32'd0);
    chk("midrst_prot", 32'(prot_err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; b_addr = 32'hC0;
    mid(); chk("postrst_req", 32'(b_req), 32'd1); chk("postrst_addr", b_addr_o, 32'hC0);
    chk("postrst_cnt", 32'(b_out), 32'd0);
    @(posedge clk); #1;
    b_gnt = 1'b1;
    mid(); chk("postrst_ready", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    b_valid = 1'b0; b_gnt = 1'b0;
    mid(); chk("postrst_cnt_after", 32'(b_out), 32'd1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
